// File: rtl/signed_sat_accumulator_if.sv
// rtl/signed_sat_accumulator_if.sv - sample stream and status bundle for the saturating accumulator
interface signed_sat_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             clear;
    logic             wrap_mode;
    logic             down_valid;
    logic [WIDTH-1:0] down_data;
    logic             sat_pos;
    logic             sat_neg;
    logic             ovf_sticky;
    logic [CNT_W-1:0] sat_cnt;

    modport master (
        output up_valid, up_data, clear, wrap_mode,
        input  down_valid, down_data, sat_pos, sat_neg, ovf_sticky, sat_cnt
    );

    modport slave (
        input  up_valid, up_data, clear, wrap_mode,
        output down_valid, down_data, sat_pos, sat_neg, ovf_sticky, sat_cnt
    );
endinterface

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - signed accumulator with saturating/wrapping add and overflow stats
module signed_sat_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    signed_sat_accumulator_if.slave  bus
);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] acc;
    logic             dv_q;
    logic             sat_pos_q;
    logic             sat_neg_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] raw_sum;
    logic             pos_ovf;
    logic             neg_ovf;
    logic             ovf;
    logic [WIDTH-1:0] sum_next;
    logic             sticky_base;
    logic [CNT_W-1:0] cnt_base;

    // Clear folds into the operands so a same-cycle sample adds onto zero.
    always_comb begin
        acc_base    = bus.clear ? '0 : acc;
        sticky_base = bus.clear ? 1'b0 : sticky_q;
        cnt_base    = bus.clear ? '0 : cnt_q;
        raw_sum     = acc_base + bus.up_data;
        pos_ovf     = !acc_base[WIDTH-1] && !bus.up_data[WIDTH-1] && raw_sum[WIDTH-1];
        neg_ovf     = acc_base[WIDTH-1] && bus.up_data[WIDTH-1] && !raw_sum[WIDTH-1];
        ovf         = pos_ovf || neg_ovf;
        sum_next    = raw_sum;
        if (!bus.wrap_mode) begin
            if (pos_ovf) begin
                sum_next = POS_MAX;
            end else if (neg_ovf) begin
                sum_next = NEG_MIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            dv_q      <= 1'b0;
            sat_pos_q <= 1'b0;
            sat_neg_q <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
        end else if (bus.up_valid) begin
            acc       <= sum_next;
            dv_q      <= 1'b1;
            sat_pos_q <= pos_ovf;
            sat_neg_q <= neg_ovf;
            sticky_q  <= sticky_base || ovf;
            cnt_q     <= (ovf && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
        end else begin
            acc       <= acc_base;
            dv_q      <= 1'b0;
            sat_pos_q <= 1'b0;
            sat_neg_q <= 1'b0;
            sticky_q  <= sticky_base;
            cnt_q     <= cnt_base;
        end
    end

    assign bus.down_valid = dv_q;
    assign bus.down_data  = acc;
    assign bus.sat_pos    = sat_pos_q;
    assign bus.sat_neg    = sat_neg_q;
    assign bus.ovf_sticky = sticky_q;
    assign bus.sat_cnt    = cnt_q;
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb/tb_signed_sat_accumulator.sv - directed and random checks of signed_sat_accumulator against an integer model
module tb_signed_sat_accumulator;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    signed_sat_accumulator_if #(.WIDTH(8), .CNT_W(8)) b  ();
    signed_sat_accumulator_if #(.WIDTH(8), .CNT_W(2)) b2 ();

    signed_sat_accumulator #(.WIDTH(8), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    signed_sat_accumulator #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    int m_acc, m_cnt;
    bit m_dv, m_sp, m_sn, m_sticky;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".down_valid"}, b.down_valid, m_dv);
        chk({tag, ".down_data"}, $signed(b.down_data), m_acc);
        chk({tag, ".sat_pos"}, b.sat_pos, m_sp);
        chk({tag, ".sat_neg"}, b.sat_neg, m_sn);
        chk({tag, ".ovf_sticky"}, b.ovf_sticky, m_sticky);
        chk({tag, ".sat_cnt"}, b.sat_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_dv = 0; m_sp = 0; m_sn = 0; m_sticky = 0;
    endtask

    // Mathematical sum in int range, then clamp or fold back into [-128,127].
    task automatic model(input bit v, input int d, input bit c, input bit w);
        int  base, s;
        bit  po, ne;
        base = c ? 0 : m_acc;
        if (c) begin
            m_sticky = 0;
            m_cnt    = 0;
        end
        m_dv = v; m_sp = 0; m_sn = 0;
        if (v) begin
            s  = base + d;
            po = s > 127;
            ne = s < -128;
            if (w) m_acc = po ? s - 256 : (ne ? s + 256 : s);
            else   m_acc = po ? 127 : (ne ? -128 : s);
            m_sp = po;
            m_sn = ne;
            if (po || ne) begin
                m_sticky = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            m_acc = base;
        end
    endtask

    task automatic step(input bit v, input int d, input bit c, input bit w, input string tag);
        b.up_valid  = v;
        b.up_data   = d[7:0];
        b.clear     = c;
        b.wrap_mode = w;
        @(posedge clk);
        model(v, d, c, w);
        #1;
        check_all(tag);
    endtask

    initial begin
        int          exp_cnt2 [5];
        logic [7:0]  rd;
        tests = 0;
        fails = 0;
        exp_cnt2 = '{0, 1, 2, 3, 3};
        b.up_valid = 0; b.up_data = 0; b.clear = 0; b.wrap_mode = 0;
        b2.up_valid = 0; b2.up_data = 0; b2.clear = 0; b2.wrap_mode = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 100, 0, 0, "sat_100");
        step(1, 50, 0, 0, "sat_50");
        chk("req035.data", $signed(b.down_data), 127);
        chk("req035.sat_pos", b.sat_pos, 1);

        step(1, -100, 1, 0, "clr_m100");
        step(1, -50, 0, 0, "sat_m50");
        chk("req036.data", $signed(b.down_data), -128);
        chk("req036.sat_neg", b.sat_neg, 1);
        step(1, 5, 0, 0, "plus5");
        chk("req036.data2", $signed(b.down_data), -123);

        step(1, 100, 1, 0, "clr_100");
        step(1, 50, 0, 1, "wrap_50");
        chk("req037.data", $signed(b.down_data), -106);
        chk("req037.sat_pos", b.sat_pos, 1);

        step(1, 127, 1, 0, "clr_127");
        step(1, 1, 0, 0, "sat_plus1");
        step(1, -7, 0, 0, "to_120");
        step(1, 7, 1, 0, "clr_with_7");
        chk("req038.data", $signed(b.down_data), 7);
        chk("req038.sticky", b.ovf_sticky, 0);

        step(0, 0, 0, 0, "idle");
        step(1, -128, 0, 0, "neg_min_add");
        step(1, -1, 0, 1, "wrap_neg");
        step(0, 0, 1, 0, "clear_only");
        step(0, 0, 0, 0, "idle_after_clear");

        for (int i = 0; i < 5; i++) begin
            b2.up_valid = 1; b2.up_data = 8'd127; b2.clear = 0; b2.wrap_mode = 0;
            @(posedge clk);
            #1;
            chk($sformatf("req039.cnt%0d", i), b2.sat_cnt, exp_cnt2[i]);
            chk($sformatf("req039.data%0d", i), $signed(b2.down_data), 127);
        end
        b2.up_valid = 0;

        for (int i = 0; i < 300; i++) begin
            rd = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 9) < 7), int'($signed(rd)), ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        step(1, 90, 0, 0, "pre_rst_a");
        step(1, 90, 0, 0, "pre_rst_b");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        b.up_valid = 0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");
        step(1, 3, 0, 0, "first_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/signed_sat_accumulator.md
SIGNED_SAT_ACCUMULATOR -- requirements
Module: signed_sat_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: two's-complement width of input samples and accumulator; legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the saturation-event counter.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port up_valid  input  1: up_data carries a sample this cycle.
REQ-006 Port up_data  input  WIDTH: signed sample.
REQ-007 Port clear  input  1: synchronous zeroing of accumulator, sticky flag and counter.
REQ-008 Port wrap_mode  input  1: 1 = modulo 2^WIDTH addition; 0 = saturating addition.
REQ-009 Port down_valid  output  1: down_data holds a freshly updated accumulator value.
REQ-010 Port down_data  output  WIDTH: signed accumulator value.
REQ-011 Port sat_pos  output  1: the update just reported clamped at positive maximum.
REQ-012 Port sat_neg  output  1: the update just reported clamped at negative minimum.
REQ-013 Port ovf_sticky  output  1: at least one overflow occurred since the last reset or clear.
REQ-014 Port sat_cnt  output  CNT_W: number of overflow events since the last reset or clear.

Function
REQ-015 POS_MAX = 0 followed by WIDTH-1 ones; NEG_MIN = 1 followed by WIDTH-1 zeros.
REQ-016 Raw sum = acc + up_data, truncated to WIDTH bits.
REQ-017 Positive overflow: acc and up_data both non-negative, raw sum MSB set.
REQ-018 Negative overflow: acc and up_data both negative, raw sum MSB clear.
REQ-019 Operands of opposite sign never overflow.
REQ-020 On up_valid with wrap_mode=0: acc <= POS_MAX on positive overflow, NEG_MIN on negative overflow, otherwise the raw sum.
REQ-021 On up_valid with wrap_mode=1: acc <= raw sum unconditionally.
REQ-022 Overflow is detected in both modes; sat_pos/sat_neg, ovf_sticky and sat_cnt update identically in either mode.
REQ-023 Latency is one cycle: down_valid is high exactly in the cycle after an accepted up_valid, and down_data then equals the new acc.
REQ-024 down_data always reflects acc, including in cycles where down_valid=0.
REQ-025 sat_pos and sat_neg are single-cycle pulses aligned with down_valid; they are never high together and never high without down_valid.
REQ-026 ovf_sticky is set by any overflow and held until clear or reset.
REQ-027 sat_cnt increments by 1 per overflow event and saturates at all-ones; it does not wrap.
REQ-028 Clear without up_valid: acc, ovf_sticky and sat_cnt become 0 next cycle, and down_valid stays 0.
REQ-029 Clear with up_valid in the same cycle: the sum is computed from acc=0, so acc <= up_data with no overflow, down_valid=1 next cycle, and ovf_sticky/sat_cnt become 0.
REQ-030 Without up_valid or clear, all state holds and the pulse outputs are 0.
REQ-031 wrap_mode is sampled per accepted sample and may change on any cycle.

Reset
REQ-032 Asserting rst_n low immediately forces acc=0, down_valid=0, sat_pos=0, sat_neg=0, ovf_sticky=0 and sat_cnt=0, independent of clk.
REQ-033 A sample presented while rst_n is low is discarded; the first accepted sample is the first one seen on a rising edge with rst_n high.
REQ-034 Reset asserted mid-stream discards the in-flight update; no down_valid pulse follows deassertion.

Verification (WIDTH=8, CNT_W=8 unless noted)
REQ-035 Saturating mode, samples 100 then 50 -> down_data 100, then 127 with sat_pos=1; ovf_sticky=1; sat_cnt=1.
REQ-036 Saturating mode from acc=-100, sample -50 -> down_data -128 with sat_neg=1; then sample +5 -> -123 with no pulse.
REQ-037 Wrap mode from acc=100, sample 50 -> down_data -106 with sat_pos=1; sat_cnt increments.
REQ-038 Clear and up_valid together with sample 7 while acc=120 and ovf_sticky=1 -> down_data 7, down_valid=1, ovf_sticky=0, sat_cnt=0.
REQ-039 CNT_W=2, five consecutive samples of +127 in saturating mode -> sat_cnt sequence 0,1,2,3,3 and down_data held at 127.
REQ-040 rst_n pulsed low between clock edges during a stream -> all outputs 0 at once, and no down_valid in the cycle after deassertion.
